// File: rtl/uart_rx_word_pkg.sv
// Shared constants, width helper and collector state encoding for the UART word receiver.
package uart_rx_word_pkg;

  localparam int unsigned DEFAULT_CLK_FREQ = 40000000;
  localparam int unsigned DEFAULT_BAUD     = 115200;

  // Collector states
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  // Ceiling log2; clog2(1) = 0
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver: mid-bit sampling, LSB first, bytes with a bad stop bit are dropped.
module uart_rx
  import uart_rx_word_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int unsigned BAUD     = DEFAULT_BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  input  logic       rx_data_ready
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CW           = (clog2(CLKS_PER_BIT) > 0) ? clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic          rx_meta;
  logic          rx_sync;
  logic [1:0]    state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RX_IDLE;
      clk_cnt       <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
    end else begin
      if (rx_data_valid && rx_data_ready) begin
        rx_data_valid <= 1'b0;
      end
      case (state)
        RX_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (!rx_sync) begin
            state <= RX_START;
          end
        end
        RX_START: begin
          // Re-check the start bit at its midpoint to reject glitches
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            shift   <= {rx_sync, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            state   <= RX_IDLE;
            if (rx_sync) begin
              rx_data       <= shift;
              rx_data_valid <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_word.sv
// Collects NUM_BYTES UART bytes into a word with a held valid/ready output,
// overrun detection and an idle timeout that discards partial words.
module uart_rx_word
  import uart_rx_word_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = DEFAULT_CLK_FREQ,
  parameter int unsigned BAUD        = DEFAULT_BAUD,
  parameter int unsigned NUM_BYTES   = 4,
  parameter int unsigned MSB_FIRST   = 1,
  parameter int unsigned TIMEOUT_CYC = 13890
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             uart_rx,
  output logic [8*NUM_BYTES-1:0]           word_data,
  output logic                             word_valid,
  input  logic                             word_ready,
  output logic [clog2(NUM_BYTES+1)-1:0]    byte_cnt,
  output logic                             overrun,
  output logic                             timeout
);

  localparam int unsigned W      = 8 * NUM_BYTES;
  localparam int unsigned CNT_W  = clog2(NUM_BYTES + 1);
  localparam int unsigned IDLE_W = (clog2(TIMEOUT_CYC + 1) > 0) ? clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(NUM_BYTES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYC - 1);

  logic [7:0]        rx_byte;
  logic              rx_valid;

  logic [0:0]        state_q, state_d;
  logic [W-1:0]      asm_q, asm_d;
  logic [W-1:0]      asm_byte;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [CNT_W-1:0]  byte_cnt_d;
  logic [W-1:0]      word_data_d;
  logic              word_valid_d;
  logic              overrun_d;
  logic              timeout_d;
  logic              last_byte;
  logic              timeout_hit;
  logic              accept;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk           (clk),
    .rst           (rst),
    .rx            (uart_rx),
    .rx_data       (rx_byte),
    .rx_data_valid (rx_valid),
    .rx_data_ready (1'b1)
  );

  always_comb begin
    accept      = word_valid && word_ready;
    last_byte   = rx_valid && (byte_cnt == LAST_IDX);
    // An arriving byte takes priority over an expiring idle period
    timeout_hit = (byte_cnt != '0) && !rx_valid && (idle_q == IDLE_LIMIT);

    // Assembly register value including the byte arriving this cycle
    asm_byte = '0;
    if (MSB_FIRST != 0) begin
      asm_byte = (byte_cnt == '0) ? W'(rx_byte) : ((asm_q << 8) | W'(rx_byte));
    end else begin
      asm_byte = (byte_cnt == '0) ? '0 : asm_q;
      asm_byte[8*int'(byte_cnt) +: 8] = rx_byte;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt;
    asm_d      = asm_q;
    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          asm_d = asm_byte;
          if (NUM_BYTES > 1) begin
            state_d    = COLLECT;
            byte_cnt_d = CNT_W'(1);
          end
        end
      end
      COLLECT: begin
        if (rx_valid) begin
          asm_d = asm_byte;
          if (last_byte) begin
            state_d    = IDLE;
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt + 1'b1;
          end
        end else if (timeout_hit) begin
          state_d    = IDLE;
          byte_cnt_d = '0;
          asm_d      = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        byte_cnt_d = '0;
        asm_d      = '0;
      end
    endcase
  end

  always_comb begin
    idle_d = '0;
    if (!rx_valid && (byte_cnt != '0) && !timeout_hit) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_comb begin
    word_data_d  = word_data;
    word_valid_d = word_valid;
    overrun_d    = 1'b0;
    timeout_d    = timeout_hit;
    if (accept) begin
      word_valid_d = 1'b0;
    end
    if (last_byte) begin
      if (!word_valid || word_ready) begin
        word_data_d  = asm_byte;
        word_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      asm_q      <= '0;
      idle_q     <= '0;
      byte_cnt   <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      asm_q      <= asm_d;
      idle_q     <= idle_d;
      byte_cnt   <= byte_cnt_d;
      word_data  <= word_data_d;
      word_valid <= word_valid_d;
      overrun    <= overrun_d;
      timeout    <= timeout_d;
    end
  end

endmodule

// File: doc/uart_rx_word.md
UART_RX_WORD -- requirements
Module: uart_rx_word

Interface
REQ-001 Parameter CLK_FREQ, default 40000000, clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 Parameter NUM_BYTES, default 4, bytes per word; legal range 1..8.
REQ-004 Parameter MSB_FIRST, default 1; 1 = first received byte lands in the most significant byte, 0 = first byte lands in the least significant byte.
REQ-005 Parameter TIMEOUT_CYC, default 13890, idle clocks after which a partial word is discarded.
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 uart_rx  input  1  serial line; idle high.
REQ-009 word_data  output  8*NUM_BYTES  assembled word; valid while word_valid=1.
REQ-010 word_valid  output  1  word available; held until accepted.
REQ-011 word_ready  input  1  consumer accepts word_data when word_valid=1 and word_ready=1.
REQ-012 byte_cnt  output  clog2(NUM_BYTES+1)  bytes collected for the current partial word.
REQ-013 overrun  output  1  one-cycle pulse: a completed word was dropped.
REQ-014 timeout  output  1  one-cycle pulse: a partial word was discarded after the idle period.

Function
REQ-015 Byte reception SHALL be delegated to sub-module uart_rx, with rx_data_ready tied to 1; each rx_data_valid pulse delivers one byte.
REQ-016 The collector FSM SHALL have states IDLE (byte_cnt=0) and COLLECT (0<byte_cnt<NUM_BYTES).
- IDLE -> COLLECT on a byte when NUM_BYTES>1.
- COLLECT -> IDLE on the final byte or on timeout.
REQ-017 With MSB_FIRST=1, the first byte SHALL load the assembly register zero-extended. Each later byte SHALL shift the register left 8 bits and insert the new byte at bits [7:0].
REQ-018 With MSB_FIRST=0, byte k (0-based) SHALL be written to bits [8k+7:8k]. The assembly register SHALL be cleared when byte 0 is written.
REQ-019 byte_cnt SHALL increment on each byte and wrap to 0 on the NUM_BYTES-th byte. It SHALL never reach NUM_BYTES.
REQ-020 On the final byte, the complete word SHALL load word_data and word_valid SHALL be 1 on the next clock edge. Latency is 1 cycle from the final rx_data_valid.
REQ-021 word_data and word_valid SHALL stay stable while word_valid=1 and word_ready=0.
REQ-022 word_valid SHALL clear on the cycle after acceptance, unless a new word completes in the same cycle as the acceptance. In that case the new word SHALL load, word_valid SHALL remain 1, and overrun SHALL stay 0.
REQ-023 If a word completes while word_valid=1 and word_ready=0:
- the new word SHALL be dropped;
- the held word SHALL be kept;
- overrun SHALL pulse for 1 cycle;
- byte_cnt SHALL still wrap to 0.
REQ-024 The idle counter SHALL reset on every byte and count only while byte_cnt!=0.
REQ-025 When the idle counter reaches TIMEOUT_CYC-1, the block SHALL set byte_cnt=0, discard the partial word, and pulse timeout for 1 cycle.
REQ-026 If a byte arrives in the same cycle the timeout would fire, the byte SHALL win and no timeout SHALL occur.
REQ-027 With NUM_BYTES=1, every byte SHALL complete a word directly from IDLE, and timeout SHALL never fire.

Reset
REQ-028 While rst=1, the block SHALL drive these values on the next clock edge: word_data=0, word_valid=0, byte_cnt=0, overrun=0, timeout=0, idle counter=0, FSM=IDLE.
REQ-029 Reset mid-word SHALL discard the partial word without a timeout pulse. Reset SHALL also drop any held word.
REQ-030 rst SHALL be passed to uart_rx with the matching active-high synchronous polarity.

Structure
REQ-031 A shared package SHALL hold:
- the default CLK_FREQ and BAUD;
- the width function clog2;
- the collector state enumeration (IDLE, COLLECT).
REQ-032 The single sub-module SHALL be uart_rx. Word assembly, the output holding register and the idle counter SHALL live in uart_rx_word.

Verification
REQ-033 Send NUM_BYTES=4, MSB_FIRST=1, bytes 0x12,0x34,0x56,0x78 with word_ready=1 -> word_data=0x12345678, word_valid high exactly 1 cycle, byte_cnt=0.
REQ-034 Send the same bytes with MSB_FIRST=0 -> word_data=0x78563412.
REQ-035 Hold word_ready=0, send word 0xAABBCCDD then word 0x11223344 -> word_data stays 0xAABBCCDD and overrun pulses once. Then raise word_ready -> word_valid clears next cycle.
REQ-036 Send 0x01,0x02, then leave the line idle for TIMEOUT_CYC cycles -> timeout pulses once and byte_cnt=0. Then send 0xA0,0xA1,0xA2,0xA3 -> word_data=0xA0A1A2A3.
REQ-037 Assert rst for 1 cycle after 3 bytes of a word -> all outputs return to 0. Then send 4 fresh bytes -> the correct new word appears, with no timeout or overrun.
REQ-038 With NUM_BYTES=1, send 0x5A -> word_data=0x5A, word_valid=1, one cycle after rx_data_valid.
